// File: rtl/pipe_alu.sv
// pipe_alu: execute-stage integer ALU with registered result and flags, 1-cycle latency.
// Optional MUL/MULHU (codes 1100/1101) enabled by defining ALU_MUL_EN.
module pipe_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             out_valid
);
  localparam int SHW = $clog2(WIDTH);
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, res;
  logic             ov;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
`endif
  assign shamt = in2[SHW-1:0];
  assign sum   = in1 + in2;
  assign diff  = in1 - in2;
  always_comb begin
    res = '0;
    ov  = 1'b0;
    case (aluctrl)
      4'b0000: res = in1 & in2;
      4'b0001: res = in1 | in2;
      4'b0010: begin
        res = sum;
        ov  = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0011: res = in1 ^ in2;
      4'b0100: res = in1 << shamt;
      4'b0101: res = in1 >> shamt;
      4'b0110: begin
        res = diff;
        ov  = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      4'b1000: res = {{(WIDTH-1){1'b0}}, in1 < in2};
      4'b1001: res = $unsigned($signed(in1) >>> shamt);
      4'b1010: res = ~(in1 | in2);
      4'b1011: res = in2;
`ifdef ALU_MUL_EN
      4'b1100: res = prod[WIDTH-1:0];
      4'b1101: res = prod[2*WIDTH-1:WIDTH];
`endif
      default: res = '0;
    endcase
  end
  // Idle cycles leave result/flags untouched so downstream logic does not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= res;
        zero   <= (res == '0);
        neg    <= res[WIDTH-1];
        ovf    <= ov;
      end
    end
  end
endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed self-checking bench for pipe_alu using immediate assertions.
module tb_pipe_alu;
  logic        clk, rst, in_valid;
  logic [3:0]  aluctrl;
  logic [31:0] in1, in2, result;
  logic        zero, neg, ovf, out_valid;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sweep_exp [16];
  logic [63:0] prod;

  pipe_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluctrl(aluctrl),
    .in1(in1), .in2(in2), .result(result), .zero(zero), .neg(neg),
    .ovf(ovf), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] r, input logic z, input logic n,
                         input logic o, input logic v);
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    chk({tag, ".neg"}, {31'd0, neg}, {31'd0, n});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, o});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    aluctrl  = c;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep_exp = '{32'h00F000F0, 32'hFFF0FFF0, 32'h00E100E0, 32'hFF00FF00,
                  32'hF0F00000, 32'h0000F0F0, 32'hE100E100, 32'h00000001,
                  32'h00000000, 32'hFFFFF0F0, 32'h000F000F, 32'h0FF00FF0,
                  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
`ifdef ALU_MUL_EN
    prod = 64'hF0F0F0F0;
    prod = prod * 64'h0FF00FF0;
    sweep_exp[12] = prod[31:0];
    sweep_exp[13] = prod[63:32];
`else
    prod = '0;
`endif
    rst = 1'b1; in_valid = 1'b0; aluctrl = '0; in1 = '0; in2 = '0;
    #12;
    chk_all("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    op(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    chk_all("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1);
    op(4'b0110, 32'h12345678, 32'h12345678);
    chk_all("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    op(4'b0110, 32'h80000000, 32'h00000001);
    chk_all("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    op(4'b0111, 32'hFFFFFFFF, 32'h00000001);
    chk("slt", result, 32'h1);
    op(4'b1000, 32'hFFFFFFFF, 32'h00000001);
    chk("sltu", result, 32'h0);
    op(4'b1001, 32'h80000000, 32'h00000024);
    chk("sra", result, 32'hF8000000);
    op(4'b0101, 32'h80000000, 32'h00000024);
    chk("srl", result, 32'h08000000);
    op(4'b0100, 32'h00000001, 32'h0000001F);
    chk_all("sll31", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    op(4'b0100, 32'h00001234, 32'hFFFFFFE0);
    chk("sll_shamt0", result, 32'h00001234);

    for (int i = 0; i < 16; i++) begin
      op(i[3:0], 32'hF0F0F0F0, 32'h0FF00FF0);
      chk($sformatf("sweep%0d.result", i), result, sweep_exp[i]);
      chk($sformatf("sweep%0d.zero", i), {31'd0, zero}, {31'd0, sweep_exp[i] == 32'h0});
      chk($sformatf("sweep%0d.ovf", i), {31'd0, ovf}, 32'h0);
      chk($sformatf("sweep%0d.out_valid", i), {31'd0, out_valid}, 32'h1);
    end

    op(4'b1010, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk_all("nor", 32'h000F000F, 1'b0, 1'b0, 1'b0, 1'b1);
    aluctrl = 4'b0010; in1 = 32'h1; in2 = 32'h1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("idle_hold", 32'h000F000F, 1'b0, 1'b0, 1'b0, 1'b0);

    op(4'b0001, 32'hA5A50000, 32'h00005A5A);
    chk_all("pre_reset", 32'hA5A55A5A, 1'b0, 1'b1, 1'b0, 1'b1);
    aluctrl = 4'b0010; in1 = 32'h7FFFFFFF; in2 = 32'h1; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_held", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    op(4'b1011, 32'h0, 32'hABCD0000);
    chk_all("post_reset", 32'hABCD0000, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
